// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V style controller: FSM states,
// datapath select codes and the opcodes the decoder recognises.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd15
  } state_t;

  // Immediate formats
  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  // ALU operand A sources
  localparam logic [1:0] SRC_A_PC     = 2'd0;
  localparam logic [1:0] SRC_A_RS1    = 2'd1;
  localparam logic [1:0] SRC_A_OLD_PC = 2'd2;

  // ALU operand B sources
  localparam logic [1:0] SRC_B_RS2    = 2'd0;
  localparam logic [1:0] SRC_B_FOUR   = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;

  // ALU operations
  localparam logic [1:0] ALU_ADD      = 2'd0;
  localparam logic [1:0] ALU_SUB      = 2'd1;
  localparam logic [1:0] ALU_FUNCT    = 2'd2;

  // Writeback sources
  localparam logic [1:0] WB_ALU_OUT   = 2'd0;
  localparam logic [1:0] WB_MEM       = 2'd1;
  localparam logic [1:0] WB_PC        = 2'd2;
  localparam logic [1:0] WB_IMM       = 2'd3;

  // Recognised opcodes
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_ALU_I  = 7'h13;
  localparam logic [6:0] OP_ALU_R  = 7'h33;

  // Branch conditions
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

endpackage

// File: rtl/wait_timer.sv
// Counts consecutive stall cycles; expired is high once the count equals
// TIMEOUT. The count saturates there so it never wraps back to zero.
module wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] count;

  assign expired = (count == W'(TIMEOUT));

  // Stall counter: reset/clear win, otherwise count up until saturated
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count_en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle controller FSM. Outputs are pure decodes of the current state,
// qualified by mem_ready_i / zero_i where a state completes conditionally.
// Memory handshake: a request is held (mem_req_o=1) until mem_ready_i is
// seen high in the same cycle; the access completes on that clock edge.
// A request stalled for TIMEOUT+1 cycles without ready sends the FSM to TRAP.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       pc_src_o,
  output logic       reg_write_o,
  output logic [2:0] imm_sel_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] wb_sel_o,
  output logic [3:0] state_o,
  output logic       trap_o
);

  state_t state_q, state_d;
  logic   waiting, count_en, expired, branch_taken;

  // Only the memory-facing states can stall
  assign waiting  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign count_en = waiting && !mem_ready_i;

  assign branch_taken = ((funct3_i == F3_BEQ) &&  zero_i) ||
                        ((funct3_i == F3_BNE) && !zero_i);

  assign state_o = state_q;

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .count_en (count_en),
    .clear    (!count_en),
    .expired  (expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic; ready always beats the timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready_i)  state_d = S_DECODE;
        else if (expired) state_d = S_TRAP;
      end
      S_DECODE: begin
        unique case (op_i)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_ALU_R:          state_d = S_EXEC_R;
          OP_ALU_I:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: state_d = (op_i == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready_i)  state_d = S_MEM_WB;
        else if (expired) state_d = S_TRAP;
      end
      S_MEM_WR: begin
        if (mem_ready_i)  state_d = S_FETCH;
        else if (expired) state_d = S_TRAP;
      end
      S_MEM_WB, S_ALU_WB, S_JAL, S_LUI: state_d = S_FETCH;
      S_EXEC_R, S_EXEC_I:               state_d = S_ALU_WB;
      S_BRANCH: begin
        if ((funct3_i == F3_BEQ) || (funct3_i == F3_BNE)) state_d = S_FETCH;
        else                                              state_d = S_TRAP;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // Output decode; anything not set for a state stays 0
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    iord_o      = 1'b0;
    ir_write_o  = 1'b0;
    pc_write_o  = 1'b0;
    pc_src_o    = 1'b0;
    reg_write_o = 1'b0;
    imm_sel_o   = IMM_NONE;
    alu_src_a_o = SRC_A_PC;
    alu_src_b_o = SRC_B_RS2;
    alu_op_o    = ALU_ADD;
    wb_sel_o    = WB_ALU_OUT;
    trap_o      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = SRC_B_FOUR;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_a_o = SRC_A_OLD_PC;
        alu_src_b_o = SRC_B_IMM;
        unique case (op_i)
          OP_LOAD, OP_ALU_I: imm_sel_o = IMM_I;
          OP_STORE:          imm_sel_o = IMM_S;
          OP_BRANCH:         imm_sel_o = IMM_B;
          OP_JAL:            imm_sel_o = IMM_J;
          OP_LUI:            imm_sel_o = IMM_U;
          default:           imm_sel_o = IMM_NONE;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_o = SRC_A_RS1;
        alu_src_b_o = SRC_B_IMM;
        imm_sel_o   = (op_i == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEM_RD: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_o = 1'b1;
        wb_sel_o    = WB_MEM;
      end
      S_MEM_WR: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        iord_o    = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a_o = SRC_A_RS1;
        alu_op_o    = ALU_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a_o = SRC_A_RS1;
        alu_src_b_o = SRC_B_IMM;
        imm_sel_o   = IMM_I;
        alu_op_o    = ALU_FUNCT;
      end
      S_ALU_WB: reg_write_o = 1'b1;
      S_BRANCH: begin
        alu_src_a_o = SRC_A_RS1;
        alu_op_o    = ALU_SUB;
        pc_write_o  = branch_taken;
        pc_src_o    = branch_taken;
      end
      S_JAL: begin
        reg_write_o = 1'b1;
        wb_sel_o    = WB_PC;
        pc_write_o  = 1'b1;
        pc_src_o    = 1'b1;
      end
      S_LUI: begin
        imm_sel_o   = IMM_U;
        reg_write_o = 1'b1;
        wb_sel_o    = WB_IMM;
      end
      S_TRAP:  trap_o = 1'b1;
      default: trap_o = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks instruction classes through
// the FSM cycle by cycle against hand-computed state/output expectations.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op_i;
  logic [2:0] funct3_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o;
  logic       reg_write_o, trap_o;
  logic [2:0] imm_sel_o;
  logic [1:0] alu_src_a_o, alu_src_b_o, alu_op_o, wb_sel_o;
  logic [3:0] state_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  multicycle_control #(.TIMEOUT(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .op_i        (op_i),
    .funct3_i    (funct3_i),
    .zero_i      (zero_i),
    .mem_ready_i (mem_ready_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .iord_o      (iord_o),
    .ir_write_o  (ir_write_o),
    .pc_write_o  (pc_write_o),
    .pc_src_o    (pc_src_o),
    .reg_write_o (reg_write_o),
    .imm_sel_o   (imm_sel_o),
    .alu_src_a_o (alu_src_a_o),
    .alu_src_b_o (alu_src_b_o),
    .alu_op_o    (alu_op_o),
    .wb_sel_o    (wb_sel_o),
    .state_o     (state_o),
    .trap_o      (trap_o)
  );

  // Scoreboard check: counts every comparison, reports mismatches
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: apply inputs mid-cycle (at negedge) and let comb outputs settle
  task automatic drive(input logic rdy, input logic z);
    mem_ready_i = rdy;
    zero_i      = z;
    #1;
  endtask

  // Advance to the next negedge (one rising edge passes)
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  // Write-enable bundle {ir_write, pc_write, pc_src, reg_write, mem_we}
  function automatic logic [4:0] we_bus();
    return {ir_write_o, pc_write_o, pc_src_o, reg_write_o, mem_we_o};
  endfunction

  initial begin
    reset = 1'b1; op_i = 7'h00; funct3_i = 3'd0; zero_i = 1'b0; mem_ready_i = 1'b0;
    @(negedge clk);

    // Reset state and first cycle after reset
    do_reset();
    drive(1'b0, 1'b0);
    check("rst_state", state_o, 0);
    check("rst_req", mem_req_o, 1);
    check("rst_iord", iord_o, 0);
    check("rst_we", we_bus(), 5'b00000);
    check("rst_trap", trap_o, 0);

    // addi with ready held high: 0,1,7,8,0; reg_write only in ALU_WB
    op_i = 7'h13; funct3_i = 3'd0;
    drive(1'b1, 1'b0);
    check("addi_s0", state_o, 0);
    check("addi_fetch_we", we_bus(), 5'b11000);
    check("addi_fetch_b", alu_src_b_o, 1);
    check("addi_rw0", reg_write_o, 0);
    tick(); drive(1'b1, 1'b0);
    check("addi_s1", state_o, 1);
    check("addi_dec_imm", imm_sel_o, 1);
    check("addi_dec_a", alu_src_a_o, 2);
    check("addi_dec_b", alu_src_b_o, 2);
    check("addi_rw1", reg_write_o, 0);
    tick(); drive(1'b1, 1'b0);
    check("addi_s7", state_o, 7);
    check("addi_exec_op", alu_op_o, 2);
    check("addi_exec_a", alu_src_a_o, 1);
    check("addi_rw7", reg_write_o, 0);
    tick(); drive(1'b1, 1'b0);
    check("addi_s8", state_o, 8);
    check("addi_rw8", reg_write_o, 1);
    check("addi_wb8", wb_sel_o, 0);
    tick(); drive(1'b1, 1'b0);
    check("addi_s0_end", state_o, 0);

    // lw with 3 stall cycles in MEM_RD
    op_i = 7'h03;
    tick(); drive(1'b1, 1'b0);
    check("lw_s1", state_o, 1);
    check("lw_dec_imm", imm_sel_o, 1);
    tick(); drive(1'b1, 1'b0);
    check("lw_s2", state_o, 2);
    check("lw_addr_imm", imm_sel_o, 1);
    for (int i = 0; i < 3; i++) begin
      tick(); drive(1'b0, 1'b0);
      check("lw_rd_wait", state_o, 3);
      check("lw_rd_req", {mem_req_o, iord_o, mem_we_o}, 3'b110);
    end
    tick(); drive(1'b1, 1'b0);
    check("lw_rd_last", state_o, 3);
    tick(); drive(1'b1, 1'b0);
    check("lw_s4", state_o, 4);
    check("lw_wb_sel", wb_sel_o, 1);
    check("lw_wb_rw", reg_write_o, 1);
    tick(); drive(1'b1, 1'b0);
    check("lw_s0", state_o, 0);

    // beq taken (zero=1) then not taken (zero=0)
    op_i = 7'h63; funct3_i = 3'b000;
    tick(); drive(1'b1, 1'b1);
    check("beq_dec_imm", imm_sel_o, 3);
    tick(); drive(1'b1, 1'b1);
    check("beq_s9", state_o, 9);
    check("beq_t_pcw", {pc_write_o, pc_src_o}, 2'b11);
    check("beq_op", alu_op_o, 1);
    tick(); drive(1'b1, 1'b0);
    check("beq_s0", state_o, 0);
    tick(); tick(); drive(1'b1, 1'b0);
    check("beq_nt_s9", state_o, 9);
    check("beq_nt_pcw", {pc_write_o, pc_src_o}, 2'b00);
    // bne with zero=0 is taken
    funct3_i = 3'b001;
    drive(1'b1, 1'b0);
    check("bne_t_pcw", {pc_write_o, pc_src_o}, 2'b11);
    // unsupported funct3 traps without a PC write
    funct3_i = 3'b010;
    drive(1'b1, 1'b1);
    check("bx_pcw", pc_write_o, 0);
    tick(); drive(1'b1, 1'b0);
    check("bx_trap_state", state_o, 15);
    check("bx_trap", trap_o, 1);

    // JAL and LUI
    do_reset();
    op_i = 7'h6F; funct3_i = 3'd0;
    drive(1'b1, 1'b0);
    tick(); drive(1'b1, 1'b0);
    check("jal_dec_imm", imm_sel_o, 5);
    tick(); drive(1'b1, 1'b0);
    check("jal_s10", state_o, 10);
    check("jal_outs", {reg_write_o, wb_sel_o, pc_write_o, pc_src_o}, 5'b11011);
    op_i = 7'h37;
    tick(); tick(); drive(1'b1, 1'b0);
    check("lui_dec_imm", imm_sel_o, 4);
    tick(); drive(1'b1, 1'b0);
    check("lui_s11", state_o, 11);
    check("lui_outs", {imm_sel_o, reg_write_o, wb_sel_o}, 6'b100111);

    // Timeout: ready stuck low in FETCH traps after 16 cycles
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0);
      check("to_fetch", state_o, 0);
      tick();
    end
    drive(1'b1, 1'b0);
    check("to_state", state_o, 15);
    check("to_trap", trap_o, 1);
    check("to_req", {mem_req_o, ir_write_o, pc_write_o}, 3'b000);
    tick(); drive(1'b1, 1'b0);
    check("to_sticky", state_o, 15);

    // Ready at count 15 wins over the timeout
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0);
    check("to_edge_fetch", state_o, 0);
    tick(); drive(1'b1, 1'b0);
    check("to_edge_dec", state_o, 1);

    // Illegal opcode traps after DECODE
    do_reset();
    op_i = 7'h7F;
    drive(1'b1, 1'b0);
    tick(); drive(1'b1, 1'b0);
    check("ill_s1", state_o, 1);
    check("ill_imm", imm_sel_o, 0);
    tick(); drive(1'b1, 1'b0);
    check("ill_trap", {state_o, trap_o}, 5'b11111);

    // Store; reset asserted mid MEM_WR abandons the access
    do_reset();
    op_i = 7'h23;
    drive(1'b1, 1'b0);
    tick(); drive(1'b1, 1'b0);
    check("sw_dec_imm", imm_sel_o, 2);
    tick(); drive(1'b0, 1'b0);
    check("sw_addr_imm", imm_sel_o, 2);
    tick(); drive(1'b0, 1'b0);
    check("sw_s5", state_o, 5);
    check("sw_wr", {mem_req_o, mem_we_o, iord_o}, 3'b111);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0);
    check("sw_rst_state", state_o, 0);
    check("sw_rst_we", mem_we_o, 0);
    check("sw_rst_req", {mem_req_o, iord_o}, 2'b10);

    // Store completing with zero-wait memory returns to FETCH
    drive(1'b1, 1'b0);
    tick(); tick(); tick(); drive(1'b1, 1'b0);
    check("sw_s5_b", state_o, 5);
    tick(); drive(1'b0, 1'b0);
    check("sw_done", state_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
